// File: rtl/fade_pkg.sv
// Shared types and colour-wheel tables for the RGB fade sequencer.
// The tables describe each phase in terms of full/zero channels so they stay width-independent.
package fade_pkg;

  typedef enum logic [2:0] {
    PH_0 = 3'd0,
    PH_1 = 3'd1,
    PH_2 = 3'd2,
    PH_3 = 3'd3,
    PH_4 = 3'd4,
    PH_5 = 3'd5
  } phase_t;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_t;

  typedef struct packed {
    logic  up;
    chan_t ch;
  } ramp_t;

  // Each bit set means that channel starts the phase at full scale, else at zero.
  typedef struct packed {
    logic r_full;
    logic g_full;
    logic b_full;
  } rgb_mask_t;

  function automatic rgb_mask_t start_duties(input phase_t p);
    case (p)
      PH_0:    start_duties = 3'b100;
      PH_1:    start_duties = 3'b110;
      PH_2:    start_duties = 3'b010;
      PH_3:    start_duties = 3'b011;
      PH_4:    start_duties = 3'b001;
      PH_5:    start_duties = 3'b101;
      default: start_duties = 3'b100;
    endcase
  endfunction

  function automatic ramp_t ramp_dir(input phase_t p);
    case (p)
      PH_0:    ramp_dir = '{up: 1'b1, ch: CH_G};
      PH_1:    ramp_dir = '{up: 1'b0, ch: CH_R};
      PH_2:    ramp_dir = '{up: 1'b1, ch: CH_B};
      PH_3:    ramp_dir = '{up: 1'b0, ch: CH_G};
      PH_4:    ramp_dir = '{up: 1'b1, ch: CH_R};
      PH_5:    ramp_dir = '{up: 1'b0, ch: CH_B};
      default: ramp_dir = '{up: 1'b1, ch: CH_G};
    endcase
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_tick_gen.sv
// Free-running wrapping counter that emits a one-cycle clock-enable strobe
// every INTERVAL enabled cycles; holds its count while en is low.
module tick_gen #(
  parameter int INTERVAL = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Walks an RGB LED around a six-phase colour wheel, ramping one channel per phase
// and producing three PWM duty values. The wheel position is visible on phase.
module rgb_fade_sequencer
  import fade_pkg::*;
#(
  parameter int TICK_INTERVAL = 12000,
  parameter int PHASE_STEPS   = 200,
  parameter int PWM_INTERVAL  = 1200
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              load,
  input  logic [2:0]                        load_phase,
  output logic [2:0]                        phase,
  output logic                              phase_done,
  output logic [$clog2(PWM_INTERVAL+1)-1:0] r_duty,
  output logic [$clog2(PWM_INTERVAL+1)-1:0] g_duty,
  output logic [$clog2(PWM_INTERVAL+1)-1:0] b_duty
);

  localparam int DW = $clog2(PWM_INTERVAL + 1);
  localparam int SW = (PHASE_STEPS > 1) ? $clog2(PHASE_STEPS) : 1;
  localparam logic [DW-1:0] FULL      = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] STEP      = DW'(PWM_INTERVAL / PHASE_STEPS);
  localparam logic [SW-1:0] LAST_STEP = SW'(PHASE_STEPS - 1);

  phase_t    phase_q;
  logic [2:0] phase_inc;
  logic [SW-1:0] step_q;
  logic      tick;
  logic      load_ok;
  logic      tick_clr;
  logic      last_step;
  phase_t    load_ph;
  ramp_t     ramp;
  rgb_mask_t load_mask;
  logic [DW-1:0] ramp_cur;
  logic [DW-1:0] ramp_nxt;

  assign load_ok   = load && (load_phase <= 3'd5);
  assign load_ph   = phase_t'(load_phase);
  assign load_mask = start_duties(load_ph);
  assign ramp      = ramp_dir(phase_q);
  assign last_step = (step_q == LAST_STEP);
  assign phase_inc = phase_q + 3'd1;
  assign phase     = phase_q;
  // A valid load restarts the tick interval along with the step counter.
  assign tick_clr  = rst || load_ok;

  tick_gen #(.INTERVAL(TICK_INTERVAL)) u_tick (
    .clk  (clk),
    .rst  (tick_clr),
    .en   (enable),
    .tick (tick)
  );

  always_comb begin
    case (ramp.ch)
      CH_R:    ramp_cur = r_duty;
      CH_G:    ramp_cur = g_duty;
      default: ramp_cur = b_duty;
    endcase
  end

  // The final step snaps to the exact target so rounding in STEP never leaves residue.
  always_comb begin
    ramp_nxt = ramp_cur;
    if (ramp.up) begin
      ramp_nxt = (last_step || ramp_cur >= FULL - STEP) ? FULL : ramp_cur + STEP;
    end else begin
      ramp_nxt = (last_step || ramp_cur <= STEP) ? '0 : ramp_cur - STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= PH_0;
      step_q     <= '0;
      r_duty     <= FULL;
      g_duty     <= '0;
      b_duty     <= '0;
      phase_done <= 1'b0;
    end else begin
      phase_done <= 1'b0;
      if (load_ok) begin
        phase_q <= load_ph;
        step_q  <= '0;
        r_duty  <= load_mask.r_full ? FULL : '0;
        g_duty  <= load_mask.g_full ? FULL : '0;
        b_duty  <= load_mask.b_full ? FULL : '0;
      end else if (tick) begin
        case (ramp.ch)
          CH_R:    r_duty <= ramp_nxt;
          CH_G:    g_duty <= ramp_nxt;
          default: b_duty <= ramp_nxt;
        endcase
        if (last_step) begin
          step_q     <= '0;
          phase_q    <= (phase_q == PH_5) ? PH_0 : phase_t'(phase_inc);
          phase_done <= 1'b1;
        end else begin
          step_q <= step_q + SW'(1);
        end
      end
    end
  end

endmodule
